// File: rtl/fe_fb_if.sv
// Fetch request/response channel between fetch control and the fetch buffer.
//   req_valid/req_addr/req_id : fetch request (one outstanding at a time)
//   kill                      : abandon the outstanding request
//   rsp_valid/rsp_instr/rsp_pc/rsp_id : instruction response
// Modports: master = fetch control side, slave = fetch buffer side.
interface fe_fb_if #(
  parameter int unsigned PADDR_W = 32,
  parameter int unsigned ID_W    = 4
);
  logic               req_valid;
  logic [PADDR_W-1:0] req_addr;
  logic [ID_W-1:0]    req_id;
  logic               kill;
  logic               rsp_valid;
  logic [31:0]        rsp_instr;
  logic [PADDR_W-1:0] rsp_pc;
  logic [ID_W-1:0]    rsp_id;

  modport master (
    output req_valid, req_addr, req_id, kill,
    input  rsp_valid, rsp_instr, rsp_pc, rsp_id
  );

  modport slave (
    input  req_valid, req_addr, req_id, kill,
    output rsp_valid, rsp_instr, rsp_pc, rsp_id
  );
endinterface

// File: rtl/fe_fb.sv
// Fetch buffer: responder side of the fetch request/response protocol. Holds a
// small fully-associative set of instruction lines; hits answer one cycle after
// the request, misses fetch the line from memory, install it and then answer.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   bus (slave)    : fetch request/response channel plus kill
//   inv_all        : invalidate every line at the next edge
//   fill_req_valid/fill_req_ready/fill_req_addr : line fill request to memory
//   fill_rsp_valid/fill_rsp_data                : single-beat line fill data
//   busy           : high whenever the FSM is not idle
//
// Build options:
//   FE_FB_BYPASS_EN : answer a miss in the same cycle the fill data arrives,
//                     taking the word straight from fill_rsp_data.
//   ASSERT          : enables the request protocol assertion.
module fe_fb #(
  parameter int unsigned NUM_LINES  = 4,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned PADDR_W    = 32,
  parameter int unsigned ID_W       = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  fe_fb_if.slave                  bus,
  input  logic                    inv_all,
  output logic                    fill_req_valid,
  input  logic                    fill_req_ready,
  output logic [PADDR_W-1:0]      fill_req_addr,
  input  logic                    fill_rsp_valid,
  input  logic [LINE_BYTES*8-1:0] fill_rsp_data,
  output logic                    busy
);

  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = PADDR_W - OFF_W;
  localparam int unsigned LINE_W = LINE_BYTES * 8;

  typedef enum logic [2:0] {
    FbIdle,
    FbLookup,
    FbFillReq,
    FbFillWait,
    FbRsp
  } fb_state_e;

  fb_state_e          state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [NUM_LINES];
  logic [LINE_W-1:0]  data_q [NUM_LINES];
  logic [IDX_W-1:0]   victim_q;
  logic [IDX_W-1:0]   rsp_idx_q;
  logic [PADDR_W-1:0] req_addr_q;
  logic [ID_W-1:0]    req_id_q;
  logic               drop_q, drop_d;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               latch;
  logic               install;
  logic               rsp_drive;
  logic               rsp_ok;
  logic [31:0]        rsp_word;
  logic               rsp_fire;

  // Pick the 32-bit word addressed by the byte offset (low two bits ignored).
  function automatic logic [31:0] sel_word(input logic [LINE_W-1:0] line,
                                           input logic [OFF_W-1:0]  off);
    logic [LINE_W-1:0] sh;
    sh = line >> {off & ~OFF_W'(3), 3'b000};
    return sh[31:0];
  endfunction

  assign req_tag = req_addr_q[PADDR_W-1:OFF_W];

  // At most one entry can match: a line is only installed after a miss.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      if (valid_q[IDX_W'(i)] && tag_q[IDX_W'(i)] == req_tag) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    latch     = 1'b0;
    install   = 1'b0;
    rsp_drive = 1'b0;
    rsp_ok    = 1'b0;
    rsp_word  = '0;
    unique case (state_q)
      FbIdle: begin
        if (bus.req_valid) begin
          latch   = 1'b1;
          state_d = FbLookup;
        end
      end
      FbLookup: begin
        if (hit) begin
          rsp_drive = 1'b1;
          rsp_ok    = !bus.kill;
          rsp_word  = sel_word(data_q[hit_idx], req_addr_q[OFF_W-1:0]);
          // kill targets the old request; a new one is still accepted
          if (bus.req_valid) begin
            latch   = 1'b1;
            state_d = FbLookup;
          end else begin
            state_d = FbIdle;
          end
        end else begin
          if (bus.kill) drop_d = 1'b1;
          state_d = FbFillReq;
        end
      end
      FbFillReq: begin
        if (bus.kill) drop_d = 1'b1;
        if (fill_req_ready) state_d = FbFillWait;
      end
      FbFillWait: begin
        if (bus.kill) drop_d = 1'b1;
        if (fill_rsp_valid) begin
          install = 1'b1;
`ifdef FE_FB_BYPASS_EN
          rsp_drive = 1'b1;
          rsp_ok    = !bus.kill && !drop_q;
          rsp_word  = sel_word(fill_rsp_data, req_addr_q[OFF_W-1:0]);
          drop_d    = 1'b0;
          if (bus.req_valid) begin
            latch   = 1'b1;
            state_d = FbLookup;
          end else begin
            state_d = FbIdle;
          end
`else
          state_d = FbRsp;
`endif
        end
      end
      FbRsp: begin
        rsp_drive = 1'b1;
        rsp_ok    = !bus.kill && !drop_q;
        rsp_word  = sel_word(data_q[rsp_idx_q], req_addr_q[OFF_W-1:0]);
        drop_d    = 1'b0;
        if (bus.req_valid) begin
          latch   = 1'b1;
          state_d = FbLookup;
        end else begin
          state_d = FbIdle;
        end
      end
      default: state_d = FbIdle;
    endcase
  end

  // Install wins over a same-cycle invalidate for the victim entry.
  always_comb begin
    valid_d = inv_all ? '0 : valid_q;
    if (install) valid_d[victim_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FbIdle;
      valid_q    <= '0;
      victim_q   <= '0;
      rsp_idx_q  <= '0;
      drop_q     <= 1'b0;
      req_addr_q <= '0;
      req_id_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      if (latch) begin
        req_addr_q <= bus.req_addr;
        req_id_q   <= bus.req_id;
      end
      if (install) begin
        victim_q  <= victim_q + IDX_W'(1);
        rsp_idx_q <= victim_q;
      end
    end
  end

  // Line storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (install) begin
      tag_q[victim_q]  <= req_tag;
      data_q[victim_q] <= fill_rsp_data;
    end
  end

  assign rsp_fire      = !reset && rsp_drive && rsp_ok;
  assign bus.rsp_valid = rsp_fire;
  assign bus.rsp_instr = rsp_fire ? rsp_word : '0;
  assign bus.rsp_pc    = rsp_fire ? req_addr_q : '0;
  assign bus.rsp_id    = rsp_fire ? req_id_q : '0;

  assign fill_req_valid = !reset && (state_q == FbFillReq);
  assign fill_req_addr  = fill_req_valid ? {req_tag, {OFF_W{1'b0}}} : '0;
  assign busy           = !reset && (state_q != FbIdle);

`ifdef ASSERT
  logic req_ok;
  always_comb begin
    req_ok = (state_q == FbIdle) || (state_q == FbLookup && hit) || (state_q == FbRsp);
`ifdef FE_FB_BYPASS_EN
    if (state_q == FbFillWait && fill_rsp_valid) req_ok = 1'b1;
`endif
  end

  a_req_protocol: assert property (@(posedge clk) disable iff (reset)
    bus.req_valid |-> req_ok);
`endif

endmodule

// File: tb/tb_fe_fb.sv
// Self-checking bench for fe_fb: directed scenarios plus randomized fetches,
// checked against a FIFO-of-resident-lines reference model.
module tb_fe_fb;
  localparam int unsigned NumLines  = 4;
  localparam int unsigned LineBytes = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         inv_all;
  logic         fill_req_valid;
  logic         fill_req_ready;
  logic [31:0]  fill_req_addr;
  logic         fill_rsp_valid;
  logic [127:0] fill_rsp_data;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] resident[$];
  logic [31:0] r_line;
  logic [31:0] r_addr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fe_fb_if #(.PADDR_W(32), .ID_W(4)) bus ();

  fe_fb #(
    .NUM_LINES (NumLines),
    .LINE_BYTES(LineBytes),
    .PADDR_W   (32),
    .ID_W      (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .inv_all       (inv_all),
    .fill_req_valid(fill_req_valid),
    .fill_req_ready(fill_req_ready),
    .fill_req_addr (fill_req_addr),
    .fill_rsp_valid(fill_rsp_valid),
    .fill_rsp_data (fill_rsp_data),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory contents: a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] la;
    logic [31:0] w;
    la = addr & 32'hFFFF_FFF0;
    w  = (addr >> 2) & 32'h3;
    if (la == 32'h100 && w == 32'd1) return 32'hDEAD_BEEF;
    return (la * 32'h9E37_79B1) ^ (w * 32'h0101_0101) ^ 32'h1234_0000;
  endfunction

  function automatic logic [127:0] line_data(input logic [31:0] la);
    logic [127:0] d;
    for (int w = 0; w < 4; w++) d[w*32 +: 32] = mem_word(la + 32'(4 * w));
    return d;
  endfunction

  function automatic bit is_res(input logic [31:0] la);
    foreach (resident[i]) if (resident[i] == la) return 1'b1;
    return 1'b0;
  endfunction

  // Round-robin replacement from a common start is oldest-first eviction.
  function automatic void install_line(input logic [31:0] la);
    if (resident.size() == NumLines) void'(resident.pop_front());
    resident.push_back(la);
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_rsp_valid"}, 128'(bus.rsp_valid), 128'(0));
    check({tag, "_rsp_instr"}, 128'(bus.rsp_instr), 128'(0));
    check({tag, "_rsp_pc"}, 128'(bus.rsp_pc), 128'(0));
    check({tag, "_rsp_id"}, 128'(bus.rsp_id), 128'(0));
    check({tag, "_fill_valid"}, 128'(fill_req_valid), 128'(0));
    check({tag, "_fill_addr"}, 128'(fill_req_addr), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] addr, input logic [3:0] id);
    check({tag, "_instr"}, 128'(bus.rsp_instr), 128'(mem_word(addr)));
    check({tag, "_pc"}, 128'(bus.rsp_pc), 128'(addr));
    check({tag, "_id"}, 128'(bus.rsp_id), 128'(id));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1 check_zero("rst_in");
    @(negedge clk);
    #1 check_zero("rst_held");
    reset = 1'b0;
    resident.delete();
  endtask

  task automatic pulse_inv();
    @(negedge clk);
    inv_all = 1'b1;
    @(negedge clk);
    inv_all = 1'b0;
    resident.delete();
  endtask

  // One request with hit or miss handling predicted by the model.
  task automatic fetch(input logic [31:0] addr, input logic [3:0] id, input bit kill_lu,
                       input bit kill_fill, input int rdly, input int fdly);
    logic [31:0] la;
    bit          hit;
    int          t0;
    int          tf;
    la  = addr & 32'hFFFF_FFF0;
    hit = is_res(la);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_id    = id;
    t0 = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.kill      = kill_lu && hit;
    #1;
    if (hit) begin
      check("hit_valid", 128'(bus.rsp_valid), 128'(!kill_lu));
      if (!kill_lu) begin
        check_rsp("hit", addr, id);
        check("hit_latency", 128'(cyc - t0), 128'(1));
      end
      check("hit_no_fill", 128'(fill_req_valid), 128'(0));
    end else begin
      check("miss_lookup_rsp", 128'(bus.rsp_valid), 128'(0));
      @(negedge clk);
      bus.kill       = 1'b0;
      fill_req_ready = 1'b0;
      #1;
      check("fill_req_valid", 128'(fill_req_valid), 128'(1));
      check("fill_req_addr", 128'(fill_req_addr), 128'(la));
      check("fill_req_latency", 128'(cyc - t0), 128'(2));
      for (int i = 0; i < rdly; i++) begin
        @(negedge clk);
        #1 check("fill_req_hold", 128'(fill_req_valid), 128'(1));
      end
      fill_req_ready = 1'b1;
      @(negedge clk);
      fill_req_ready = 1'b0;
      bus.kill       = kill_fill;
      for (int i = 0; i < fdly; i++) begin
        #1;
        check("wait_no_rsp", 128'(bus.rsp_valid), 128'(0));
        check("wait_no_fill_req", 128'(fill_req_valid), 128'(0));
        @(negedge clk);
        bus.kill = 1'b0;
      end
      fill_rsp_valid = 1'b1;
      fill_rsp_data  = line_data(la);
      tf = cyc;
      #1;
      install_line(la);
`ifdef FE_FB_BYPASS_EN
      check("byp_rsp_valid", 128'(bus.rsp_valid), 128'(!kill_fill));
      if (!kill_fill) check_rsp("byp_rsp", addr, id);
`else
      check("fill_cycle_no_rsp", 128'(bus.rsp_valid), 128'(0));
`endif
      @(negedge clk);
      fill_rsp_valid = 1'b0;
      bus.kill       = 1'b0;
      #1;
`ifdef FE_FB_BYPASS_EN
      check("byp_idle_busy", 128'(busy), 128'(0));
      check("byp_idle_rsp", 128'(bus.rsp_valid), 128'(0));
`else
      check("miss_rsp_valid", 128'(bus.rsp_valid), 128'(!kill_fill));
      if (!kill_fill) begin
        check_rsp("miss_rsp", addr, id);
        check("miss_latency", 128'(cyc - tf), 128'(1));
      end
`endif
    end
  endtask

  // Four back-to-back hit requests, one response per cycle.
  task automatic stream4(input logic [31:0] base);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) begin
        bus.req_valid = 1'b1;
        bus.req_addr  = base + 32'(4 * k);
        bus.req_id    = 4'(k + 8);
      end else begin
        bus.req_valid = 1'b0;
      end
      #1;
      if (k > 0) begin
        check("stream_valid", 128'(bus.rsp_valid), 128'(1));
        check_rsp("stream", base + 32'(4 * (k - 1)), 4'(k + 7));
        check("stream_no_fill", 128'(fill_req_valid), 128'(0));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    inv_all        = 1'b0;
    fill_req_ready = 1'b0;
    fill_rsp_valid = 1'b0;
    fill_rsp_data  = '0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_id     = '0;
    bus.kill       = 1'b0;
    do_reset();

    // Cold miss then hit on the neighbouring word.
    fetch(32'h100, 4'd0, 1'b0, 1'b0, 0, 2);
    fetch(32'h104, 4'd1, 1'b0, 1'b0, 0, 0);
    check("cold_word1_model", 128'(mem_word(32'h104)), 128'(32'hDEAD_BEEF));

    stream4(32'h100);

    // Kill on a hit suppresses the response.
    fetch(32'h108, 4'd2, 1'b1, 1'b0, 0, 0);

    // Kill during fill: no response, line still installed.
    fetch(32'h200, 4'd3, 1'b0, 1'b1, 1, 2);
    fetch(32'h200, 4'd4, 1'b0, 1'b0, 0, 0);

    // Replacement wrap: five lines into four entries, first line evicted.
    do_reset();
    for (int i = 0; i < 5; i++) fetch(32'h1000 + 32'(16 * i), 4'(i), 1'b0, 1'b0, i % 2, 1);
    fetch(32'h1000, 4'd5, 1'b0, 1'b0, 0, 0);
    fetch(32'h1030, 4'd6, 1'b0, 1'b0, 0, 0);

    // inv_all then a miss on a previously resident line.
    fetch(32'h100, 4'd7, 1'b0, 1'b0, 0, 0);
    pulse_inv();
    fetch(32'h100, 4'd8, 1'b0, 1'b0, 0, 1);

    // Reset while in the fill-request state, then a late fill beat.
    pulse_inv();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h180;
    bus.req_id    = 4'd9;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    #1 check("rstfill_req_valid", 128'(fill_req_valid), 128'(1));
    reset = 1'b1;
    #1 check_zero("rstfill_in");
    @(negedge clk);
    #1 check_zero("rstfill_held");
    reset = 1'b0;
    resident.delete();
    @(negedge clk);
    fill_rsp_valid = 1'b1;
    fill_rsp_data  = line_data(32'h180);
    #1;
    check("late_fill_busy", 128'(busy), 128'(0));
    check("late_fill_rsp", 128'(bus.rsp_valid), 128'(0));
    @(negedge clk);
    fill_rsp_valid = 1'b0;
    fetch(32'h180, 4'd10, 1'b0, 1'b0, 0, 0);

    // Randomized traffic over six lines so eviction keeps happening.
    for (int n = 0; n < 60; n++) begin
      r_line = 32'h3000 + 32'($urandom_range(0, 5)) * 32'd16;
      r_addr = r_line + 32'($urandom_range(0, 3)) * 32'd4;
      if ($urandom_range(0, 9) == 0) pulse_inv();
      fetch(r_addr, 4'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    #1 check("final_idle", 128'(busy), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fe_fb.md
# fe_fb

Fetch buffer: the responder side of the fetch request/response protocol. It accepts one instruction-fetch request at a time from the fetch control block and holds a small fully-associative buffer of instruction lines. Hits return one 32-bit instruction on the response channel one cycle later. Misses issue a line fill to the memory side, install the returned line, then respond.

## Interface
- NUM_LINES, 4: number of line entries; power of two, >=2.
- LINE_BYTES, 16: bytes per line; power of two, >=4.
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- fe_fb_req_nnn  input  t_fe_fb_req  fields: valid, addr (t_paddr), id.
- fb_fe_rsp_nnn  output  t_fb_fe_rsp  fields: valid, instr (t_rv_instr), pc (t_paddr), id.
- kill_nnn  input  1  abandon the outstanding request; no response is returned for it.
- inv_all  input  1  invalidate every line.
- fill_req_valid  output  1  line fill request.
- fill_req_ready  input  1  memory accepts the fill request.
- fill_req_addr  output  t_paddr  line-aligned address; low log2(LINE_BYTES) bits are 0.
- fill_rsp_valid  input  1  fill data is valid; one beat per line.
- fill_rsp_data  input  LINE_BYTES*8  full line, byte 0 in bits [7:0].
- busy  output  1  high in any state other than FB_IDLE.

## Operation
- Storage: per entry a valid bit, a tag (addr[paddr-1:log2(LINE_BYTES)]) and line data. A round-robin victim pointer of log2(NUM_LINES) bits wraps from NUM_LINES-1 to 0 and advances on every install.
- Request latch: on an accepted request, addr and id are registered as req_q. The response pc is req_q.addr. The response instr is the line word selected by req_q.addr[log2(LINE_BYTES)-1:2].
- FSM states:
  - FB_IDLE: on req.valid, latch and go to FB_LOOKUP.
  - FB_LOOKUP: compare tags against req_q.
    - Hit: drive the response. If a new req.valid arrives in this cycle, latch it and stay in FB_LOOKUP; otherwise go to FB_IDLE.
    - Miss: go to FB_FILL_REQ.
  - FB_FILL_REQ: fill_req_valid=1 with the line address of req_q. Hold until fill_req_ready, then go to FB_FILL_WAIT.
  - FB_FILL_WAIT: on fill_rsp_valid, write the victim entry (valid=1, tag, data) and go to FB_RSP.
  - FB_RSP: drive the response from the installed line. A new request in the same cycle is latched and goes to FB_LOOKUP; otherwise go to FB_IDLE.
- req.valid in any state other than FB_IDLE, FB_LOOKUP-with-hit, or FB_RSP is a protocol violation. Under ASSERT it fires an assertion and the request is ignored.
- kill_nnn:
  - In FB_LOOKUP or FB_RSP: response valid is suppressed that cycle. A request arriving in the same cycle is still accepted, because kill applies to the old request.
  - In FB_FILL_REQ or FB_FILL_WAIT: set drop_q. The fill completes and installs normally. drop_q then suppresses the FB_RSP response and clears on leaving FB_RSP.
- inv_all: all valid bits clear at the next edge. A lookup in the same cycle uses the pre-invalidate state. A fill returning in the same cycle as inv_all still installs, because install wins for the victim entry.
- reset: all valid bits 0, victim pointer 0, drop_q 0, state FB_IDLE, and all outputs 0 including fb_fe_rsp_nnn (all fields), fill_req_valid, fill_req_addr and busy. Reset mid-fill abandons the fill. A late fill_rsp_valid in FB_IDLE is ignored.
- An address already in the buffer is never installed twice, because a miss implies no match.

## Timing
- Hit latency: request at cycle N, response valid at N+1. Back-to-back hits sustain one response per cycle.
- Miss latency: request at N, lookup at N+1, fill_req_valid from N+2. With ready at R and fill_rsp_valid at F, the response is at F+1.
- Responses are combinational from state and storage registers. fill_req_valid and fill_req_addr are registered-state-driven, with no combinational path from fill_req_ready.

## Configuration
- FE_FB_BYPASS_EN defined: in FB_FILL_WAIT the response is driven in the same cycle as fill_rsp_valid, with the word taken directly from fill_rsp_data. FB_RSP is skipped, and the next state follows the FB_RSP rules. Miss response arrives at cycle F.
- Not defined: behaviour as above, with the response at F+1.

## Test plan
- Cold miss: reset, request addr 0x100 id 0, fill_req_ready tied 1, fill returns data at cycle 6 with word1 = 0xDEADBEEF. Then request 0x104.
  - Required: fill_req_addr=0x100; the 0x100 response comes at cycle 7 (6 with the macro).
  - Required: the 0x104 response has instr 0xDEADBEEF, one cycle after its request, with no fill.
- Streaming hits: requests 0x100, 0x104, 0x108, 0x10C issued in back-to-back cycles after the line is installed.
  - Required: four consecutive response cycles with pc 0x100 through 0x10C.
- Replacement wrap: fill 5 distinct lines with NUM_LINES=4, then request line 0 again.
  - Required: victim pointer sequence 0,1,2,3,0; line 0 misses again and refills.
- Kill during fill: request 0x200, assert kill_nnn in FB_FILL_WAIT, fill returns, then request 0x200 again.
  - Required: no response for the first request; the second request hits with a 1-cycle response.
- inv_all plus reset mid-fill: install 0x100, pulse inv_all, then request 0x100.
  - Required: the request misses.
  - Then assert reset in FB_FILL_REQ and drive fill_rsp_valid afterwards. Required: outputs all 0 and state FB_IDLE; the late fill is not installed.
